usb_rx_bit_timer: RTL
=====================

Name: usb_rx_bit_timer

Overview:
- Receive-side bit-timing controller for the USB 1.1 full-speed PHY.
- Consumes already-synchronized D+/D- levels from the two-flop input synchronizers.
- Recovers bit timing with an edge-resynchronized phase counter and schedules one sample per bit.
- Performs NRZI decode, bit-unstuffing and EOP detection, then hands decoded bits to the packet decoder with a single-cycle strobe.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time (minimum 4).
- SAMPLE_PHASE, 3, phase count at which the line is sampled (must be < CLKS_PER_BIT).

Ports:
- clk  input  1  system clock (CLKS_PER_BIT x 12 MHz).
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- d_plus_sync  input  1  synchronized D+.
- d_minus_sync  input  1  synchronized D-.
- rx_enable  input  1  receiver enable. When 0, the block is forced to IDLE next cycle.
- bit_valid  output  1  one-cycle strobe; bit_out is valid.
- bit_out  output  1  NRZI-decoded, unstuffed data bit.
- rx_active  output  1  high from the first K after idle until EOP completes or an abort occurs.
- eop  output  1  one-cycle pulse when SE0,SE0,J is recognized.
- stuff_err  output  1  one-cycle pulse when a stuffed bit is not 0; packet aborted.

Behaviour:
- Reset and reset-value rules:
  - All outputs reset to 0; state = IDLE; phase = 0; ones_cnt = 0; prev_level = 1 (J).
  - rst asserted mid-packet takes effect on the next posedge; no eop or stuff_err is generated.
- Line states: J = (D+=1, D-=0); K = (0,1); SE0 = (0,0); SE1 = (1,1), treated as SE0.
- Edge detect: d_plus_q is a register of d_plus_sync. An edge exists when d_plus_sync != d_plus_q, and is evaluated only when not SE0/SE1.
- Phase counter:
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - On an edge in RECEIVE, phase loads 1 in the same cycle, so the edge cycle counts as phase 0.
  - An edge coincident with the wrap cycle also loads 1 (edge wins).
- Sample point: a sample occurs when phase == SAMPLE_PHASE in RECEIVE or EOP_WAIT. The sample uses the current d_plus_sync/d_minus_sync.
- States:
  - IDLE: rx_active = 0. J->K transition (K seen while d_plus_q = 1) -> RECEIVE; phase = 1; prev_level = 1; ones_cnt = 0; rx_active = 1 from the next cycle.
  - RECEIVE, sample is J or K:
    - NRZI: bit = (level == prev_level); then prev_level = level.
    - If ones_cnt == 6: the bit is stuffed. A 0 means drop it (no bit_valid) and clear ones_cnt. A 1 means pulse stuff_err and go to IDLE.
    - Otherwise: bit_valid = 1 and bit_out = bit, both in the cycle after the sample (latency 1). ones_cnt increments on 1 and clears on 0.
  - RECEIVE, sample is SE0: go to EOP_WAIT; no bit_valid.
  - EOP_WAIT, next sample:
    - SE0: stay; se0_cnt++.
    - J with se0_cnt >= 1 (i.e. at least 2 SE0 samples): pulse eop, go to IDLE, rx_active = 0 the same cycle eop is asserted.
    - J after only 1 SE0, or K: go to IDLE without eop (abort).
    - se0_cnt saturates at 3. A fourth SE0 sample means abort to IDLE (bus reset; not this block's concern).
- rx_enable = 0 in any state: next state IDLE, rx_active = 0, no eop/stuff_err/bit_valid.
- Output exclusivity:
  - bit_valid, eop and stuff_err are mutually exclusive in any cycle.
  - bit_valid is never asserted while rx_active = 0.

Test Plan:
- Reset: hold rst for 2 cycles with lines at K -> all outputs 0, no bit_valid afterward until a J->K transition.
- Sync reception: idle J, then KJKJKJKK at 8 clk/bit, then SE0,SE0,J ->
  - bits 0,0,0,0,0,0,0,1 on bit_valid, each 1 cycle after phase 3.
  - eop pulses once; rx_active falls with eop.
- Bit stuffing, valid: after sync, send seven constant-level bits (6 ones) then a transition ->
  - exactly six 1s delivered; stuffed 0 suppressed; next data bit delivered normally.
- Bit stuffing, error: seven constant levels after six 1s -> stuff_err pulse, rx_active 0, no further bit_valid.
- Drift tracking: bit periods alternating 7 and 9 clocks over 32 bits -> all bits decoded correctly.
- Abort cases:
  - Single-sample SE0 then J -> no eop, return to IDLE.
  - rx_enable deasserted mid-packet -> rx_active 0 within 1 cycle, no eop.
  - rst asserted mid-packet -> all outputs 0 next cycle.

Source files
------------

// File: rtl/usb_rx_bit_timer.sv
// USB 1.1 full-speed receive bit timer: edge-resynchronised sampling, NRZI decode,
// bit-unstuffing and EOP detection on already-synchronised D+/D- levels.
module usb_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PHASE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  input  logic rx_enable,
  output logic bit_valid,
  output logic bit_out,
  output logic rx_active,
  output logic eop,
  output logic stuff_err
);

  localparam int unsigned PhaseW = $clog2(CLKS_PER_BIT);
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(CLKS_PER_BIT - 1);
  localparam logic [PhaseW-1:0] SamplePh  = PhaseW'(SAMPLE_PHASE);
  localparam logic [PhaseW-1:0] PhaseOne  = PhaseW'(1);

  typedef enum logic [1:0] {StIdle, StReceive, StEopWait} state_e;

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [2:0]        ones_cnt_q, ones_cnt_d;
  logic [1:0]        se0_cnt_q, se0_cnt_d;
  logic              prev_level_q, prev_level_d;
  logic              d_plus_q;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_out_q, bit_out_d;
  logic              eop_q, eop_d;
  logic              stuff_err_q, stuff_err_d;

  logic              line_se0, edge_det, sample, nrzi_bit;
  logic [PhaseW-1:0] phase_next;

  // SE1 is treated as SE0; edges are only meaningful on a differential level.
  assign line_se0   = (d_plus_sync == d_minus_sync);
  assign edge_det   = !line_se0 && (d_plus_sync != d_plus_q);
  assign sample     = (state_q != StIdle) && (phase_q == SamplePh);
  assign nrzi_bit   = (d_plus_sync == prev_level_q);
  assign phase_next = (phase_q == LastPhase) ? '0 : phase_q + PhaseOne;

  // d_plus_q clears to 0 so a line parked at K out of reset is not taken as a J->K start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      ones_cnt_q   <= '0;
      se0_cnt_q    <= '0;
      prev_level_q <= 1'b1;
      d_plus_q     <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_out_q    <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ones_cnt_q   <= ones_cnt_d;
      se0_cnt_q    <= se0_cnt_d;
      prev_level_q <= prev_level_d;
      d_plus_q     <= d_plus_sync;
      bit_valid_q  <= bit_valid_d;
      bit_out_q    <= bit_out_d;
      eop_q        <= eop_d;
      stuff_err_q  <= stuff_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ones_cnt_d   = ones_cnt_q;
    se0_cnt_d    = se0_cnt_q;
    prev_level_d = prev_level_q;
    bit_valid_d  = 1'b0;
    bit_out_d    = bit_out_q;
    eop_d        = 1'b0;
    stuff_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        phase_d = '0;
        if (!line_se0 && !d_plus_sync && d_plus_q) begin
          state_d      = StReceive;
          phase_d      = PhaseOne;
          prev_level_d = 1'b1;
          ones_cnt_d   = '0;
        end
      end
      StReceive: begin
        phase_d = edge_det ? PhaseOne : phase_next;
        if (sample) begin
          if (line_se0) begin
            state_d   = StEopWait;
            se0_cnt_d = '0;
          end else begin
            prev_level_d = d_plus_sync;
            if (ones_cnt_q == 3'd6) begin
              // Stuffed position: a 0 is discarded, a 1 is a protocol violation.
              if (nrzi_bit) begin
                stuff_err_d = 1'b1;
                state_d     = StIdle;
              end else begin
                ones_cnt_d = '0;
              end
            end else begin
              bit_valid_d = 1'b1;
              bit_out_d   = nrzi_bit;
              ones_cnt_d  = nrzi_bit ? ones_cnt_q + 3'd1 : '0;
            end
          end
        end
      end
      StEopWait: begin
        phase_d = phase_next;
        if (sample) begin
          if (line_se0) begin
            if (se0_cnt_q == 2'd2) begin
              se0_cnt_d = 2'd3;
              state_d   = StIdle;
            end else begin
              se0_cnt_d = se0_cnt_q + 2'd1;
            end
          end else begin
            eop_d   = d_plus_sync && (se0_cnt_q >= 2'd1);
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!rx_enable) begin
      state_d     = StIdle;
      phase_d     = '0;
      bit_valid_d = 1'b0;
      eop_d       = 1'b0;
      stuff_err_d = 1'b0;
    end
  end

  always_comb begin
    bit_valid = bit_valid_q;
    bit_out   = bit_out_q;
    eop       = eop_q;
    stuff_err = stuff_err_q;
    rx_active = (state_q != StIdle);
  end

endmodule
